// File: rtl/frame_buffer_ram.sv
// Single-clock frame buffer: one write port, one registered read port, hardware clear sweep.
// Optional CLEAR_ON_RESET_EN: reset launches a sweep with fill=FILL instead of idling.
module frame_buffer_ram #(
   parameter int                DATA_W = 2,
   parameter int                WIDTH  = 330,
   parameter int                HEIGHT = 330,
   parameter int                ADDR_W = 18,
   parameter logic [DATA_W-1:0] FILL   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_en,
   input  logic [ADDR_W-1:0] r_addr,
   output logic [DATA_W-1:0] r_data,
   output logic              r_valid,
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_data,
   output logic              busy,
   output logic              clear_done,
   output logic              w_drop
);

   localparam int                DEPTH  = WIDTH * HEIGHT;
   localparam int                MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   (* ramstyle = "M9K" *) logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] fill;

   logic              w_in_range, r_in_range;
   logic              we;
   logic [MEM_AW-1:0] wa;
   logic [DATA_W-1:0] wd;

   assign w_in_range = {1'b0, w_addr} < DEPTH_X;
   assign r_in_range = {1'b0, r_addr} < DEPTH_X;

   // The sweep owns the write port while in CLEAR; reset blocks every write so an abort is immediate.
   always_comb begin
      we = 1'b0;
      wa = w_addr[MEM_AW-1:0];
      wd = w_data;
      if (!reset) begin
         if (state == CLEAR) begin
            we = 1'b1;
            wa = cnt[MEM_AW-1:0];
            wd = fill;
         end else if (w_en && w_in_range) begin
            we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   // Forward the write that lands on the same edge so a read never returns stale data.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_en;
         if (r_en) begin
            if (!r_in_range)
               r_data <= '0;
            else if (we && (wa == r_addr[MEM_AW-1:0]))
               r_data <= wd;
            else
               r_data <= mem[r_addr[MEM_AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         fill       <= FILL;
         clear_done <= 1'b0;
         w_drop     <= 1'b0;
`ifdef CLEAR_ON_RESET_EN
         state      <= CLEAR;
         busy       <= 1'b1;
`else
         state      <= IDLE;
         busy       <= 1'b0;
`endif
      end else begin
         clear_done <= 1'b0;
         w_drop     <= w_en && ((state == CLEAR) || !w_in_range);
         case (state)
            IDLE: begin
               if (clear_req) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  fill  <= clear_data;
                  cnt   <= '0;
               end
            end
            CLEAR: begin
               if (cnt == LAST) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  clear_done <= 1'b1;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_buffer_ram.sv
// Bench for frame_buffer_ram on a 4x4 frame; reference is a plain array updated from the behavioural rules.
module tb_frame_buffer_ram;

   localparam int         DW = 2;
   localparam int         AW = 18;
   localparam int         D  = 16;
   localparam logic [1:0] FILLV = 2'b10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          w_en = 1'b0, r_en = 1'b0, clear_req = 1'b0;
   logic [AW-1:0] w_addr = '0, r_addr = '0;
   logic [DW-1:0] w_data = '0, clear_data = '0;
   logic [DW-1:0] r_data;
   logic          r_valid, busy, clear_done, w_drop;

   int            errs = 0;
   int            checks = 0;
   logic [DW-1:0] ref_mem [D];
   logic [DW-1:0] exp_r;
   bit            known;

   always #5 clk = ~clk;

   frame_buffer_ram #(
      .DATA_W(DW), .WIDTH(4), .HEIGHT(4), .ADDR_W(AW), .FILL(FILLV)
   ) dut (
      .clk(clk), .reset(reset),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .r_en(r_en), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
      .clear_req(clear_req), .clear_data(clear_data),
      .busy(busy), .clear_done(clear_done), .w_drop(w_drop)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Sweep writes address i on the i-th busy edge; optional dropped write at busy cycle wcyc+1.
   task automatic sweep(input logic [1:0] f, input bit start, input bit rd, input int wcyc);
      int a;
      if (start) begin
         if (w_en && (w_addr < AW'(D))) ref_mem[w_addr[3:0]] = w_data;
         clear_req  = 1'b1;
         clear_data = f;
         step;
         clear_req = 1'b0;
         w_en      = 1'b0;
         chk("kick_no_drop", 32'(w_drop), 32'(0));
      end
      for (int i = 0; i < D; i++) begin
         chk("busy_in_sweep", 32'(busy), 32'(1));
         chk("no_done_early", 32'(clear_done), 32'(0));
         a      = $urandom_range(0, D-1);
         r_en   = rd;
         r_addr = AW'(a);
         if (i == wcyc) begin
            w_en = 1'b1; w_addr = '0; w_data = ~f;
         end
         if (i == 5) begin
            clear_req = 1'b1; clear_data = ~f;
         end
         step;
         ref_mem[i] = f;
         chk("sweep_drop", 32'(w_drop), 32'(i == wcyc));
         if (rd) chk("sweep_read", 32'(r_data), 32'(ref_mem[a]));
         w_en = 1'b0; clear_req = 1'b0; r_en = 1'b0;
      end
      chk("busy_end", 32'(busy), 32'(0));
      chk("done_pulse", 32'(clear_done), 32'(1));
      step;
      chk("done_once", 32'(clear_done), 32'(0));
   endtask

   task automatic rdall;
      for (int a = 0; a < D; a++) begin
         r_en = 1'b1; r_addr = AW'(a);
         step;
         chk("rdall_valid", 32'(r_valid), 32'(1));
         chk("rdall_data", 32'(r_data), 32'(ref_mem[a]));
      end
      r_en = 1'b0;
      step;
      chk("rd_idle_valid", 32'(r_valid), 32'(0));
      chk("rd_idle_hold", 32'(r_data), 32'(ref_mem[D-1]));
   endtask

   initial begin
      int we, wa, re, ra;
      logic [1:0] wd;
      logic exp_drop;

      reset = 1'b1;
      step; step;
`ifdef CLEAR_ON_RESET_EN
      chk("rst_busy", 32'(busy), 32'(1));
      known = 1'b1;
`else
      chk("rst_busy", 32'(busy), 32'(0));
      known = 1'b0;
`endif
      chk("rst_rdata", 32'(r_data), 32'(0));
      chk("rst_rvalid", 32'(r_valid), 32'(0));
      chk("rst_done", 32'(clear_done), 32'(0));
      chk("rst_drop", 32'(w_drop), 32'(0));
      reset = 1'b0;
`ifdef CLEAR_ON_RESET_EN
      sweep(FILLV, 1'b0, 1'b0, -1);
      rdall;
`endif
      // Fill 01, user write rejected at busy cycle 3, clear_req mid-sweep ignored.
      sweep(2'b01, 1'b1, known, 2);
      rdall;

      w_en = 1'b1; w_addr = 5; w_data = 2'b11;
      step;
      ref_mem[5] = 2'b11;
      w_en = 1'b0; r_en = 1'b1; r_addr = 5;
      step;
      chk("rd5_data", 32'(r_data), 32'(2'b11));
      chk("rd5_valid", 32'(r_valid), 32'(1));
      r_en = 1'b0;
      step;
      chk("rd5_idle_valid", 32'(r_valid), 32'(0));
      chk("rd5_hold", 32'(r_data), 32'(2'b11));

      w_en = 1'b1; w_addr = 10; w_data = 2'b01;
      step;
      ref_mem[10] = 2'b01;
      w_data = 2'b10; r_en = 1'b1; r_addr = 10;
      step;
      ref_mem[10] = 2'b10;
      chk("fwd_data", 32'(r_data), 32'(2'b10));
      w_en = 1'b0; r_en = 1'b0;

      // 108900 aliases address 4 in the low bits, so a missing range check corrupts entry 4.
      w_en = 1'b1; w_addr = 108900; w_data = ~ref_mem[4];
      step;
      chk("oor_drop", 32'(w_drop), 32'(1));
      w_en = 1'b0; r_en = 1'b1; r_addr = 108900;
      step;
      chk("oor_drop_once", 32'(w_drop), 32'(0));
      chk("oor_rdata", 32'(r_data), 32'(0));
      chk("oor_rvalid", 32'(r_valid), 32'(1));
      r_addr = 4;
      step;
      chk("oor_unchanged", 32'(r_data), 32'(ref_mem[4]));
      r_en = 1'b0;
      step;

      exp_r = '0;
      for (int k = 0; k < 60; k++) begin
         we = $urandom_range(0, 1); wa = $urandom_range(0, 19); wd = 2'($urandom);
         re = (k == 0) ? 1 : $urandom_range(0, 1); ra = $urandom_range(0, 19);
         w_en = we[0]; w_addr = AW'(wa); w_data = wd;
         r_en = re[0]; r_addr = AW'(ra);
         exp_drop = (we != 0) && (wa >= D);
         if (we != 0 && wa < D) ref_mem[wa] = wd;
         if (re != 0) exp_r = (ra < D) ? ref_mem[ra] : 2'b00;
         step;
         chk("rnd_drop", 32'(w_drop), 32'(exp_drop));
         chk("rnd_valid", 32'(r_valid), 32'(re[0]));
         chk("rnd_data", 32'(r_data), 32'(exp_r));
      end
      w_en = 1'b0; r_en = 1'b0;

      // Write in the same cycle as clear_req lands, then the sweep overwrites it.
      w_en = 1'b1; w_addr = 7; w_data = 2'b00;
      sweep(2'b11, 1'b1, 1'b1, -1);
      rdall;

`ifndef CLEAR_ON_RESET_EN
      clear_req = 1'b1; clear_data = 2'b00;
      step;
      clear_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step;
         ref_mem[i] = 2'b00;
      end
      reset = 1'b1;
      step;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(clear_done), 32'(0));
      reset = 1'b0;
      for (int i = 0; i < 18; i++) begin
         step;
         chk("abort_no_done", 32'(clear_done), 32'(0));
         chk("abort_idle", 32'(busy), 32'(0));
      end
      rdall;
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
